instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared constants and types for the instruction fetch unit
// Purpose: boot address, instruction length, buffer entry width and fetch FSM states.
// Ports: none (package).
package instr_fetch_pkg;

  localparam logic [31:0] BOOT_ADDR = 32'h0000_8000;
  localparam int unsigned INSTR_LEN = 4;
  localparam int unsigned ENTRY_W   = 64;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry instruction buffer with flush
// Purpose: holds fetched {instr, pc} pairs until the decoder takes them.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   flush_i        drop every entry this edge (wins over push/pop)
//   push_i/push_data_i  write one {instr, pc} entry
//   pop_i          remove head entry
//   valid_o/full_o/count_o  occupancy status
//   head_o         oldest entry, zero after reset
module fetch_fifo
  import instr_fetch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic               valid_o,
  output logic               full_o,
  output logic [1:0]         count_o,
  output logic [ENTRY_W-1:0] head_o
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic               wptr_q;
  logic               rptr_q;
  logic [1:0]         cnt_q;
  logic               do_push;
  logic               do_pop;

  assign do_push = push_i && (cnt_q != 2'd2);
  assign do_pop  = pop_i && (cnt_q != 2'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with two-entry credit-limited buffer
// Purpose: issues word fetches, tracks in-order responses, buffers them for the
//          decoder and handles redirects by discarding stale responses.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   instr_req_o/instr_addr_o/instr_gnt_i        fetch request channel
//   instr_rvalid_i/instr_rdata_i                in-order response channel
//   redirect_i/redirect_addr_i                  taken control transfer
//   fetch_valid_o/fetch_instr_o/fetch_pc_o/fetch_ready_i  decoder handshake
module instr_fetch #(
  parameter logic [31:0] BOOT_ADDR  = instr_fetch_pkg::BOOT_ADDR,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  input  logic        fetch_ready_i
);

  localparam logic [2:0] CREDIT_MAX = 3'(FIFO_DEPTH);

  instr_fetch_pkg::fetch_state_e state_q, state_d;

  logic [31:0] addr_q, addr_d;
  logic [31:0] tgt_q, tgt_d;
  logic        stale_q, stale_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [1:0]  disc_q, disc_d;
  logic [31:0] out_pc_q [2];
  logic [31:0] out_pc_d [2];

  logic [2:0]  credit;
  logic        req;
  logic        grant;
  logic        drop;
  logic        push;
  logic        pop;
  logic [1:0]  slot;
  logic [31:0] redirect_tgt;
  logic        unused_addr_bits;

  logic        fifo_valid;
  logic        fifo_full;
  logic [1:0]  fifo_cnt;
  logic [63:0] fifo_head;

  assign redirect_tgt     = {redirect_addr_i[31:2], 2'b00};
  assign unused_addr_bits = ^redirect_addr_i[1:0];

  // Credit uses registered counts only, so a pop in the same cycle frees nothing.
  assign credit = {1'b0, out_cnt_q} + {1'b0, fifo_cnt};
  assign req    = (state_q == instr_fetch_pkg::REQ) && (credit < CREDIT_MAX);
  assign grant  = req && instr_gnt_i;
  assign drop   = instr_rvalid_i && (redirect_i || (disc_q != 2'd0));
  assign push   = instr_rvalid_i && !drop;
  assign pop    = fifo_valid && fetch_ready_i && !redirect_i;
  // Queue position the granted address lands in once any retiring response shifts out.
  assign slot   = out_cnt_q - {1'b0, instr_rvalid_i};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tgt_d     = tgt_q;
    stale_d   = stale_q;
    out_pc_d  = out_pc_q;
    out_cnt_d = out_cnt_q + {1'b0, grant} - {1'b0, instr_rvalid_i};
    disc_d    = disc_q;

    if (instr_rvalid_i) begin
      out_pc_d[0] = out_pc_q[1];
    end
    if (grant) begin
      if (slot == 2'd0) begin
        out_pc_d[0] = addr_q;
      end else begin
        out_pc_d[1] = addr_q;
      end
    end

    // Everything still in flight after a redirect edge belongs to the old stream.
    if (redirect_i) begin
      disc_d = out_cnt_d;
    end else begin
      disc_d = disc_q - {1'b0, (instr_rvalid_i && (disc_q != 2'd0))}
                      + {1'b0, (grant && stale_q)};
    end

    // A request already on the bus keeps its address until granted; the
    // redirect target is parked and that grant is later counted as stale.
    if (redirect_i) begin
      if (req && !instr_gnt_i) begin
        stale_d = 1'b1;
        tgt_d   = redirect_tgt;
      end else begin
        addr_d  = redirect_tgt;
        stale_d = 1'b0;
      end
    end else if (grant) begin
      if (stale_q) begin
        addr_d  = tgt_q;
        stale_d = 1'b0;
      end else begin
        addr_d  = addr_q + 32'(instr_fetch_pkg::INSTR_LEN);
      end
    end

    unique case (state_q)
      instr_fetch_pkg::BOOT: state_d = instr_fetch_pkg::REQ;
      instr_fetch_pkg::REQ: begin
        if (grant && !redirect_i && (credit == CREDIT_MAX - 3'd1)) begin
          state_d = instr_fetch_pkg::HOLD;
        end
      end
      instr_fetch_pkg::HOLD: begin
        if (redirect_i || (credit < CREDIT_MAX)) begin
          state_d = instr_fetch_pkg::REQ;
        end
      end
      default: state_d = instr_fetch_pkg::BOOT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= instr_fetch_pkg::BOOT;
      addr_q      <= BOOT_ADDR;
      tgt_q       <= BOOT_ADDR;
      stale_q     <= 1'b0;
      out_cnt_q   <= 2'd0;
      disc_q      <= 2'd0;
      out_pc_q[0] <= '0;
      out_pc_q[1] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tgt_q     <= tgt_d;
      stale_q   <= stale_d;
      out_cnt_q <= out_cnt_d;
      disc_q    <= disc_d;
      out_pc_q  <= out_pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i ({instr_rdata_i, out_pc_q[0]}),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full),
    .count_o     (fifo_cnt),
    .head_o      (fifo_head)
  );

  assign instr_req_o   = req;
  assign instr_addr_o  = addr_q;
  assign fetch_valid_o = fifo_valid && !redirect_i;
  assign fetch_instr_o = fifo_head[63:32];
  assign fetch_pc_o    = fifo_head[31:0];

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && instr_rvalid_i) begin
      assert (!fifo_full && !((disc_q == 2'd0) && (out_cnt_q == 2'd0)))
        else $error("instr_fetch: response with no outstanding request or no buffer space");
    end
  end
`endif

endmodule
